// File: rtl/imem_loader.sv
// Boot loader: byte stream -> instruction memory writes.
// Holds the core in reset until the whole image is written.
module imem_loader #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            byte_i,
    input  logic                  byte_valid_i,
    output logic                  byte_ready_o,
    input  logic                  start_i,
    output logic                  wr_en_o,
    output logic [ADDR_WIDTH-1:0] wr_addr_o,
    output logic [DATA_WIDTH-1:0] wr_data_o,
    output logic                  load_done_o,
    output logic                  error_o,
    output logic                  cpu_reset_n_o
);

    // One extra bit so a count of exactly capacity is representable.
    localparam int WI_W = ADDR_WIDTH - 1;
    localparam logic [16:0] CAP = 17'(1 << (ADDR_WIDTH - 2));

    typedef enum logic [2:0] {
        LEN_LO,
        LEN_HI,
        DATA,
        WRITE,
        DONE,
        ERR
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [15:0]             count_q;
    logic [WI_W-1:0]         word_idx_q;
    logic [1:0]              byte_idx_q;
    logic [23:0]             shift_q;
    logic [ADDR_WIDTH-1:0]   wr_addr_q;
    logic [DATA_WIDTH-1:0]   wr_data_q;

    logic                    accept;
    logic [15:0]             full_count;
    logic                    last_word;

    assign byte_ready_o  = (state_q == LEN_LO) ||
                           (state_q == LEN_HI) ||
                           (state_q == DATA);
    assign accept        = byte_valid_i && byte_ready_o;
    assign full_count    = {byte_i, count_q[7:0]};
    assign last_word     = (17'(word_idx_q) + 17'd1) ==
                           {1'b0, count_q};

    assign wr_en_o       = (state_q == WRITE);
    assign wr_addr_o     = wr_addr_q;
    assign wr_data_o     = wr_data_q;
    assign load_done_o   = (state_q == DONE);
    assign error_o       = (state_q == ERR);
    assign cpu_reset_n_o = (state_q == DONE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LEN_LO;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; bytes only advance the FSM when accepted.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            LEN_LO: begin
                if (accept) state_d = LEN_HI;
            end
            LEN_HI: begin
                if (accept) begin
                    if (full_count == 16'd0)
                        state_d = DONE;
                    else if ({1'b0, full_count} > CAP)
                        state_d = ERR;
                    else
                        state_d = DATA;
                end
            end
            DATA: begin
                if (accept && byte_idx_q == 2'd3)
                    state_d = WRITE;
            end
            WRITE: begin
                state_d = last_word ? DONE : DATA;
            end
            DONE, ERR: begin
                if (start_i) state_d = LEN_LO;
            end
            default: state_d = LEN_LO;
        endcase
    end

    // Count capture, little-endian word assembly and write staging.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q    <= '0;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            shift_q    <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            unique case (state_q)
                LEN_LO: begin
                    if (accept) count_q[7:0] <= byte_i;
                end
                LEN_HI: begin
                    if (accept) begin
                        count_q[15:8] <= byte_i;
                        word_idx_q    <= '0;
                        byte_idx_q    <= '0;
                    end
                end
                DATA: begin
                    if (accept) begin
                        byte_idx_q <= byte_idx_q + 2'd1;
                        unique case (byte_idx_q)
                            2'd0: shift_q[7:0]   <= byte_i;
                            2'd1: shift_q[15:8]  <= byte_i;
                            2'd2: shift_q[23:16] <= byte_i;
                            default: begin
                                wr_data_q <= DATA_WIDTH'(
                                    {byte_i, shift_q});
                                wr_addr_q <= {
                                    word_idx_q[ADDR_WIDTH-3:0],
                                    2'b00};
                            end
                        endcase
                    end
                end
                WRITE: begin
                    word_idx_q <= word_idx_q + WI_W'(1);
                end
                DONE, ERR: begin
                    if (start_i) begin
                        count_q    <= '0;
                        word_idx_q <= '0;
                        byte_idx_q <= '0;
                        shift_q    <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
